// File: rtl/jtaglet_multi_tap.sv
// jtaglet_multi_tap: IEEE 1149.1 TAP with IDCODE, BYPASS and NUM_CH user data channels
module jtaglet_multi_tap #(
  parameter int                IR_LEN       = 4,
  parameter int                NUM_CH       = 4,
  parameter int                DATA_LEN     = 32,
  parameter logic [IR_LEN-1:0] USER_BASE_OP = IR_LEN'(8),
  parameter logic [3:0]        ID_PARTVER   = 4'h0,
  parameter logic [15:0]       ID_PARTNUM   = 16'h0000,
  parameter logic [10:0]       ID_MANF      = 11'h000
) (
  input  logic                         tck,
  input  logic                         trst,
  input  logic                         tms,
  input  logic                         tdi,
  output logic                         tdo,
  output logic                         tdo_en,
  input  logic [NUM_CH*DATA_LEN-1:0]   user_data_in,
  output logic [NUM_CH*DATA_LEN-1:0]   user_data_out,
  output logic [NUM_CH-1:0]            user_capture,
  output logic [NUM_CH-1:0]            user_update,
  output logic [IR_LEN-1:0]            ir_active,
  output logic [3:0]                   tap_state
);
  localparam logic [IR_LEN-1:0] BYPASS_OP = '1;
  localparam logic [IR_LEN-1:0] IDCODE_OP = {{(IR_LEN-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
    SH_IR = 4'hA, EX1_IR = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } state_e;

  // A user opcode that lands on IDCODE or BYPASS could never be selected
  for (genvar k = 0; k < NUM_CH; k++) begin : g_op_chk
    if (IR_LEN'(USER_BASE_OP + k) == IDCODE_OP || IR_LEN'(USER_BASE_OP + k) == BYPASS_OP) begin : g_bad
      $error("user channel opcode collides with IDCODE or BYPASS");
    end
  end

  state_e                       state_q, state_d;
  logic [IR_LEN-1:0]            ir_sr_q, ir_sr_d, ir_active_q, ir_active_d;
  logic [63:0]                  dr_sr_q, dr_sr_d, cap_src;
  logic [NUM_CH*DATA_LEN-1:0]   user_data_out_q, user_data_out_d;
  logic [NUM_CH-1:0]            user_update_q, user_update_d, ch_hit, ch_sel;
  logic                         tdo_q, tdo_d, tdo_en_q, tdo_en_d, is_idcode, is_bypass;
  logic [5:0]                   dr_msb;

  always_comb begin
    is_idcode = ir_active_q == IDCODE_OP;
    is_bypass = ir_active_q == BYPASS_OP;
    for (int i = 0; i < NUM_CH; i++) ch_hit[i] = ir_active_q == IR_LEN'(USER_BASE_OP + i);
    ch_sel = (is_idcode || is_bypass) ? '0 : ch_hit;
    dr_msb = is_idcode ? 6'd31 : (|ch_sel) ? 6'(DATA_LEN - 1) : 6'd0;
    cap_src = is_idcode ? 64'({ID_PARTVER, ID_PARTNUM, ID_MANF, 1'b1}) : 64'd0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sel[i]) cap_src = 64'(user_data_in[i*DATA_LEN +: DATA_LEN]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tms ? TLR      : RTI;
      RTI:      state_d = tms ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
      SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_d = tms ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
      SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_d = tms ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  always_comb begin
    ir_sr_d = state_q == CAP_IR ? IR_LEN'(1) :
              state_q == SH_IR  ? {tdi, ir_sr_q[IR_LEN-1:1]} : ir_sr_q;
    ir_active_d = state_d == TLR    ? IDCODE_OP :
                  state_q == UPD_IR ? ir_sr_q : ir_active_q;
    dr_sr_d = dr_sr_q;
    if (state_q == CAP_DR) dr_sr_d = cap_src;
    if (state_q == SH_DR) begin
      dr_sr_d = {1'b0, dr_sr_q[63:1]};
      dr_sr_d[dr_msb] = tdi;
    end
    user_update_d = state_q == UPD_DR ? ch_sel : '0;
    user_data_out_d = user_data_out_q;
    for (int i = 0; i < NUM_CH; i++)
      if (user_update_d[i]) user_data_out_d[i*DATA_LEN +: DATA_LEN] = dr_sr_q[DATA_LEN-1:0];
    tdo_d = state_q == SH_IR ? ir_sr_q[0] : state_q == SH_DR ? dr_sr_q[0] : 1'b0;
    tdo_en_d = state_q == SH_IR || state_q == SH_DR;
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q         <= TLR;
      ir_sr_q         <= IDCODE_OP;
      ir_active_q     <= IDCODE_OP;
      dr_sr_q         <= '0;
      user_data_out_q <= '0;
      user_update_q   <= '0;
    end else begin
      state_q         <= state_d;
      ir_sr_q         <= ir_sr_d;
      ir_active_q     <= ir_active_d;
      dr_sr_q         <= dr_sr_d;
      user_data_out_q <= user_data_out_d;
      user_update_q   <= user_update_d;
    end
  end

  // Launch on the falling edge so the host samples stable data on the next rise
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo           = tdo_q;
  assign tdo_en        = tdo_en_q;
  assign user_data_out = user_data_out_q;
  assign user_update   = user_update_q;
  assign user_capture  = state_q == CAP_DR ? ch_sel : '0;
  assign ir_active     = ir_active_q;
  assign tap_state     = state_q;
endmodule

// File: tb/tb_jtaglet_multi_tap.sv
// tb_jtaglet_multi_tap: directed scan-sequence bench for jtaglet_multi_tap
module tb_jtaglet_multi_tap;
  logic         tck = 1'b0, trst = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic         tdo, tdo_en;
  logic [127:0] user_data_in = {32'h5, 32'h13579BDF, 32'h1, 32'hAAAA0000};
  logic [127:0] user_data_out;
  logic [3:0]   user_capture, user_update, ir_active, tap_state;
  int           checks = 0, failures = 0;

  logic [3:0] enc  [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
  logic [3:0] nxt0 [16] = '{4'hC, 4'hC, 4'h6, 4'h2, 4'h2, 4'h3, 4'h3, 4'h2, 4'hC, 4'hE, 4'hA, 4'hA, 4'hB, 4'hB, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'hF, 4'h7, 4'h4, 4'h1, 4'h1, 4'h5, 4'h0, 4'h5, 4'h7, 4'hF, 4'h9, 4'h9, 4'hD, 4'h8, 4'hD, 4'h7};
  logic [7:0] path [16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A, 8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
  int         plen [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

  jtaglet_multi_tap #(
    .IR_LEN(4), .NUM_CH(4), .DATA_LEN(32), .USER_BASE_OP(4'h8),
    .ID_PARTVER(4'h1), .ID_PARTNUM(16'h2345), .ID_MANF(11'h06F)
  ) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .user_data_in(user_data_in), .user_data_out(user_data_out),
    .user_capture(user_capture), .user_update(user_update),
    .ir_active(ir_active), .tap_state(tap_state)
  );

  always #5 tck = ~tck;

  task automatic tick(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #2;
  endtask

  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout,
                          output logic en_all, output logic [3:0] cap);
    dout = '0;
    en_all = 1'b1;
    tick(1, 0);
    tick(0, 0);
    cap = user_capture;
    tick(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      en_all &= tdo_en;
      tick(i == n - 1, din[i]);
    end
    tick(1, 0);
    tick(0, 0);
  endtask

  task automatic shift_ir(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] ir_pre);
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      dout[i] = tdo;
      tick(i == 3, din[i]);
    end
    tick(1, 0);
    ir_pre = ir_active;
    tick(0, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge tck);
    #2;
    checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL reset_state got=%h exp=f", tap_state); end
    checks++; if (ir_active !== 4'hE) begin failures++; $display("FAIL reset_ir got=%h exp=e", ir_active); end
    checks++; if (user_data_out !== '0 || user_update !== 4'h0) begin failures++; $display("FAIL reset_user got=%h/%b exp=0/0", user_data_out, user_update); end
    checks++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin failures++; $display("FAIL reset_tdo got=%b%b exp=00", tdo, tdo_en); end
    trst = 1'b1;
    tick(1, 0);
    checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL reset_hold got=%h exp=f", tap_state); end
    tick(0, 0);
    checks++; if (tap_state !== 4'hC || tdo_en !== 1'b0) begin failures++; $display("FAIL reset_rti got=%h/%b exp=c/0", tap_state, tdo_en); end
  endtask

  task automatic test_idcode();
    logic [63:0] dout;
    logic        en;
    logic [3:0]  cap;
    shift_dr(64'd0, 32, dout, en, cap);
    checks++; if (dout !== 64'h123450DF) begin failures++; $display("FAIL idcode_tdo got=%h exp=123450df", dout); end
    checks++; if (en !== 1'b1 || tdo_en !== 1'b0) begin failures++; $display("FAIL idcode_en got=%b/%b exp=1/0", en, tdo_en); end
    checks++; if (cap !== 4'h0) begin failures++; $display("FAIL idcode_cap got=%b exp=0000", cap); end
  endtask

  task automatic test_ir();
    logic [3:0] dout, pre;
    shift_ir(4'hF, dout, pre);
    checks++; if (dout !== 4'b0001) begin failures++; $display("FAIL ir_tdo got=%b exp=0001", dout); end
    checks++; if (pre !== 4'hE) begin failures++; $display("FAIL ir_shadow got=%h exp=e", pre); end
    checks++; if (ir_active !== 4'hF) begin failures++; $display("FAIL ir_update got=%h exp=f", ir_active); end
  endtask

  task automatic test_bypass();
    logic [63:0] dout;
    logic        en;
    logic [3:0]  cap, d4, pre;
    shift_dr(64'h0B2, 9, dout, en, cap);
    checks++; if (dout !== 64'h164 || en !== 1'b1) begin failures++; $display("FAIL bypass_f got=%h/%b exp=164/1", dout, en); end
    shift_ir(4'h3, d4, pre);
    checks++; if (ir_active !== 4'h3) begin failures++; $display("FAIL ir_op3 got=%h exp=3", ir_active); end
    shift_dr(64'h0B2, 9, dout, en, cap);
    checks++; if (dout !== 64'h164) begin failures++; $display("FAIL bypass_3 got=%h exp=164", dout); end
  endtask

  task automatic test_user();
    logic [63:0] dout;
    logic        en;
    logic [3:0]  cap, d4, pre;
    shift_ir(4'hA, d4, pre);
    shift_dr(64'hDEADBEEF, 32, dout, en, cap);
    checks++; if (dout !== 64'h13579BDF) begin failures++; $display("FAIL user_cap0 got=%h exp=13579bdf", dout); end
    checks++; if (cap !== 4'b0100) begin failures++; $display("FAIL user_capture got=%b exp=0100", cap); end
    checks++; if (user_update !== 4'b0100) begin failures++; $display("FAIL user_update got=%b exp=0100", user_update); end
    checks++; if (user_data_out !== {32'h0, 32'hDEADBEEF, 64'h0}) begin failures++; $display("FAIL user_out2 got=%h", user_data_out); end
    tick(0, 0);
    checks++; if (user_update !== 4'b0000 || user_capture !== 4'b0000) begin failures++; $display("FAIL user_pulse got=%b/%b exp=0000/0000", user_update, user_capture); end
    shift_ir(4'h8, d4, pre);
    shift_dr(64'h11223344, 32, dout, en, cap);
    checks++; if (user_update !== 4'b0001) begin failures++; $display("FAIL user_update0 got=%b exp=0001", user_update); end
    checks++; if (user_data_out !== {32'h0, 32'hDEADBEEF, 32'h0, 32'h11223344}) begin failures++; $display("FAIL user_out0 got=%h", user_data_out); end
    shift_ir(4'hA, d4, pre);
    user_data_in[95:64] = 32'h0BADF00D;
    shift_dr(64'h0BADF00D, 32, dout, en, cap);
    checks++; if (dout !== 64'h0BADF00D || cap !== 4'b0100) begin failures++; $display("FAIL user_recap got=%h/%b exp=0badf00d/0100", dout, cap); end
  endtask

  task automatic test_pause();
    logic [63:0] dout;
    logic [31:0] din;
    din = 32'hCAFEF00D;
    dout = '0;
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 32; i++) begin
      dout[i] = tdo;
      tick(i == 15 || i == 31, din[i]);
      if (i == 15) begin
        tick(0, 0);
        tick(0, 0);
        tick(1, 0);
        tick(0, 0);
      end
    end
    tick(1, 0);
    tick(0, 0);
    checks++; if (dout !== 64'h0BADF00D) begin failures++; $display("FAIL pause_tdo got=%h exp=0badf00d", dout); end
    checks++; if (user_data_out[95:64] !== 32'hCAFEF00D) begin failures++; $display("FAIL pause_out got=%h exp=cafef00d", user_data_out[95:64]); end
  endtask

  task automatic test_reset_mid();
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1);
    trst = 1'b0;
    #1;
    checks++; if (tap_state !== 4'hF || ir_active !== 4'hE) begin failures++; $display("FAIL mid_state got=%h/%h exp=f/e", tap_state, ir_active); end
    checks++; if (user_data_out !== '0 || user_update !== 4'h0) begin failures++; $display("FAIL mid_user got=%h/%b exp=0/0", user_data_out, user_update); end
    checks++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin failures++; $display("FAIL mid_tdo got=%b%b exp=00", tdo, tdo_en); end
    trst = 1'b1;
    tick(1, 0);
    checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL mid_release got=%h exp=f", tap_state); end
  endtask

  task automatic test_tms_walk();
    logic [3:0] exp_s;
    for (int s = 0; s < 16; s++) begin
      for (int t = 0; t < 2; t++) begin
        for (int j = 0; j < 5; j++) tick(1, 0);
        for (int j = 0; j < plen[s]; j++) tick(path[s][j], 0);
        checks++; if (tap_state !== enc[s]) begin failures++; $display("FAIL walk_reach got=%h exp=%h", tap_state, enc[s]); end
        tick(t[0], 0);
        exp_s = t[0] ? nxt1[s] : nxt0[s];
        checks++; if (tap_state !== exp_s) begin failures++; $display("FAIL walk_next from=%h tms=%0d got=%h exp=%h", enc[s], t, tap_state, exp_s); end
        for (int j = 0; j < 5; j++) tick(1, 0);
        checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL walk_tlr got=%h exp=f", tap_state); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir();
    test_bypass();
    test_user();
    test_pause();
    test_reset_mid();
    test_tms_walk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
